// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one fixed-latency block memory
// between the instruction-cache miss path and the data-cache miss/writeback
// path. One access at a time: grant, LATENCY busy cycles, one done cycle.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int unsigned LATENCY = 20,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLK_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    // instruction side
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [BLK_W-1:0]  i_rdata,
    // data side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic              d_done,
    output logic [BLK_W-1:0]  d_rdata,
    // backing memory
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             owner_d;    // 1 = data side owns the current access
    logic             last_i;     // 1 = most recent grant went to the instruction side
    logic             we_q;       // latched write flag of the current access
    logic             grant;
    logic             grant_d;
    logic             last_beat;

    // Byte-offset bits select a word inside the block and are not needed here.
    logic unused_offset;
    assign unused_offset = ^{i_addr[2:0], d_addr[2:0]};

    assign last_beat = (count == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, grant decision and per-state outputs.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant = 1'b1;
                    // data wins when alone, or on a tie when instruction went last
                    grant_d    = d_req && (!i_req || last_i);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_en = 1'b1;
                busy   = 1'b1;
                mem_we = we_q && last_beat;
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                i_done     = !owner_d;
                d_done     = owner_d;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching at grant, busy-cycle counting and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            owner_d   <= 1'b1;
            last_i    <= 1'b1;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else if (grant) begin
            owner_d   <= grant_d;
            last_i    <= !grant_d;
            we_q      <= grant_d && d_we;
            mem_addr  <= grant_d ? d_addr[ADDR_W-1:3] : i_addr[ADDR_W-1:3];
            mem_wdata <= d_wdata;
            count     <= '0;
        end else if (state == BUSY) begin
            count <= count + CNT_W'(1);
            if (last_beat && !we_q) begin
                if (owner_d) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized request
// stream, checked against a transaction-level model (round-robin pointer,
// shadow memory, expected held read data).
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned L = 20;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (LATENCY = 20)
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [63:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [28:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        busy;

    mem_arbiter #(.LATENCY(L), .ADDR_W(32), .BLK_W(64)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // short-latency instance
    logic        reset2;
    logic        i_req2;
    logic [31:0] i_addr2;
    logic        i_done2;
    logic [63:0] i_rdata2;
    logic        d_req2;
    logic        d_we2;
    logic [31:0] d_addr2;
    logic [63:0] d_wdata2;
    logic        d_done2;
    logic [63:0] d_rdata2;
    logic        mem_en2;
    logic        mem_we2;
    logic [28:0] mem_addr2;
    logic [63:0] mem_wdata2;
    logic [63:0] mem_rdata2;
    logic        busy2;

    mem_arbiter #(.LATENCY(2), .ADDR_W(32), .BLK_W(64)) dut2 (
        .clk(clk), .reset(reset2),
        .i_req(i_req2), .i_addr(i_addr2), .i_done(i_done2), .i_rdata(i_rdata2),
        .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
        .d_done(d_done2), .d_rdata(d_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2)
    );

    assign mem_rdata2 = {32'hA5A5_5A5A, 3'b000, mem_addr2};

    // backing memory for the main instance (64 blocks, aliased on low index bits)
    logic [63:0] env_mem [64];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [63:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) env_mem[pre_idx] <= pre_data;
        else if (mem_we) env_mem[mem_addr[5:0]] <= mem_wdata;
    end

    assign mem_rdata = env_mem[mem_addr[5:0]];

    // reference model state
    int          compared   = 0;
    int          mismatched = 0;
    bit          ptr_i;          // 1 = last grant went to I
    logic [63:0] exp_mem [64];
    logic [63:0] i_exp;
    logic [63:0] d_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve one access: call with requests set up before the grant edge.
    // Returns after the idle cycle following done, winner's req dropped.
    task automatic do_access();
        bit          win_d;
        bit          wr;
        logic [28:0] idx;
        logic [63:0] wd;
        win_d = d_req && (!i_req || ptr_i);
        ptr_i = !win_d;
        idx   = win_d ? d_addr[31:3] : i_addr[31:3];
        wr    = win_d && d_we;
        wd    = d_wdata;
        for (int unsigned k = 0; k < L; k++) begin
            @(posedge clk); #1;
            // winner's inputs change after the grant; latched values must stick
            if (win_d) begin
                d_addr  = $urandom;
                d_wdata = {$urandom, $urandom};
                d_we    = 1'($urandom_range(0, 1));
            end else begin
                i_addr = $urandom;
            end
            @(negedge clk);
            chk("busy_mem_en", mem_en, 1);
            chk("busy_flag", busy, 1);
            chk("busy_mem_addr", mem_addr, idx);
            chk("busy_mem_we", mem_we, wr && (k == L - 1));
            chk("busy_i_done", i_done, 0);
            chk("busy_d_done", d_done, 0);
            if (wr) chk("busy_mem_wdata", mem_wdata, wd);
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (wr) exp_mem[idx[5:0]] = wd;
        else if (win_d) d_exp = exp_mem[idx[5:0]];
        else i_exp = exp_mem[idx[5:0]];
        chk("done_i_done", i_done, !win_d);
        chk("done_d_done", d_done, win_d);
        chk("done_mem_en", mem_en, 0);
        chk("done_mem_we", mem_we, 0);
        chk("done_busy", busy, 1);
        chk("done_i_rdata", i_rdata, i_exp);
        chk("done_d_rdata", d_rdata, d_exp);
        @(posedge clk); #1;
        if (win_d) d_req = 1'b0;
        else i_req = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_i_done", i_done, 0);
        chk("idle_d_done", d_done, 0);
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req2 = 1'b0; i_addr2 = 32'h0000_0100;
        d_req2 = 1'b0; d_we2 = 1'b0; d_addr2 = '0; d_wdata2 = '0;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;
        ptr_i = 1'b1; i_exp = '0; d_exp = '0;

        // preload memory while reset is held
        for (int unsigned n = 0; n < 64; n++) begin
            @(posedge clk); #1;
            pre_en   = 1'b1;
            pre_idx  = 6'(n);
            pre_data = (n == 2) ? 64'h1111_2222_3333_4444 : {$urandom, $urandom};
            exp_mem[n] = pre_data;
        end
        @(posedge clk); #1;
        pre_en = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // tie right after reset: D first, I at edge 22
        @(posedge clk); #1;
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        do_access();
        do_access();
        chk("tie_i_block2", i_rdata, 64'h1111_2222_3333_4444);

        // D write then D read of the same block
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 64'hDEAD_BEEF_0000_0001;
        do_access();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        do_access();
        chk("wr_rd_back", d_rdata, 64'hDEAD_BEEF_0000_0001);

        // I-only read with address scrambled mid-access
        i_req = 1'b1; i_addr = 32'h0000_0010;
        do_access();
        chk("i_only_block2", i_rdata, 64'h1111_2222_3333_4444);

        // reset during BUSY cycle 10 of a write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0048; d_wdata = {$urandom, $urandom};
        for (int unsigned k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_busy", busy, 1);
            chk("abort_mem_we", mem_we, 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0;
        ptr_i = 1'b1; i_exp = '0; d_exp = '0;
        @(negedge clk);
        chk("abort_busy_after", busy, 0);
        chk("abort_mem_en_after", mem_en, 0);
        chk("abort_d_rdata_clr", d_rdata, 0);
        chk("abort_i_rdata_clr", i_rdata, 0);
        for (int unsigned k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_done", d_done, 0);
            chk("abort_no_we", mem_we, 0);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0048;
        do_access();

        // reset and request on the same edge: no grant
        reset = 1'b1; i_req = 1'b1; i_addr = 32'h0000_0018;
        @(posedge clk); #1;
        reset = 1'b0;
        ptr_i = 1'b1; i_exp = '0; d_exp = '0;
        @(negedge clk);
        chk("rst_req_busy", busy, 0);
        chk("rst_req_mem_en", mem_en, 0);
        do_access();

        // randomized request stream
        for (int unsigned it = 0; it < 40; it++) begin
            if (!i_req && ($urandom_range(0, 1) == 1)) begin
                i_req  = 1'b1;
                i_addr = $urandom & 32'hFFFF_FE7F;
            end
            if (!d_req && ($urandom_range(0, 1) == 1)) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom & 32'hFFFF_FE7F;
                d_wdata = {$urandom, $urandom};
            end
            if (!i_req && !d_req) begin
                i_req  = 1'b1;
                i_addr = $urandom & 32'hFFFF_FE7F;
            end
            do_access();
        end
        if (i_req || d_req) do_access();

        // LATENCY = 2 instance with a held request
        @(posedge clk); #1;
        reset2 = 1'b0; i_req2 = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            int unsigned ph;
            @(posedge clk); #1;
            @(negedge clk);
            ph = k % 4;
            chk("l2_mem_en", mem_en2, ph < 2);
            chk("l2_i_done", i_done2, ph == 2);
            chk("l2_busy", busy2, ph != 3);
            chk("l2_d_done", d_done2, 0);
            chk("l2_mem_we", mem_we2, 0);
            chk("l2_d_rdata", d_rdata2, 0);
            chk("l2_mem_wdata", mem_wdata2, 0);
            if (ph < 2) chk("l2_mem_addr", mem_addr2, 29'h20);
            if (ph == 2) chk("l2_i_rdata", i_rdata2, {32'hA5A5_5A5A, 32'h0000_0020});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single fixed-latency backing memory (64-bit blocks) between the instruction-cache miss path and the data-cache miss/writeback path.
- Accepts level requests from both sides and picks one by round-robin.
- Holds the latched block address on the memory for LATENCY cycles, then captures the block and returns it with a one-cycle done pulse.
- Sits between the two cache controllers and the memory array; the memory array itself holds no counter.

Parameters:
- LATENCY, 20: memory access time in cycles (≥2); the number of BUSY cycles per access.
- ADDR_W, 32: byte-address width from the requesters.
- BLK_W, 64: block width; one block = two 32-bit words, block index = addr[ADDR_W-1:3].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-side miss request, level.
- i_addr  in  ADDR_W  instruction byte address.
- i_done  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  BLK_W  returned instruction block.
- d_req  in  1  data-side request, level.
- d_we  in  1  1 = block write (writeback), 0 = block read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  BLK_W  writeback block.
- d_done  out  1  one-cycle pulse; d_rdata is valid (write: completion only).
- d_rdata  out  BLK_W  returned data block.
- mem_en  out  1  high throughout an access (all BUSY cycles).
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W-3  block index to memory.
- mem_wdata  out  BLK_W  write block to memory.
- mem_rdata  in  BLK_W  memory read data; valid by the last BUSY cycle.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset: state IDLE, count 0, owner D, last-grant pointer = I (so D wins the first tie). All outputs 0, including i_rdata, d_rdata, mem_addr and mem_wdata.
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when i_req or d_req is sampled high at an edge.
  - Only one requester high: that requester wins.
  - Both high: the side not granted last wins; the pointer is updated to the winner.
  - At that grant edge: latch owner, we (d_we if D, else 0), addr[ADDR_W-1:3] into mem_addr, and d_wdata into mem_wdata; set count = 0.
- BUSY: mem_en = 1.
  - count increments each edge.
  - On the edge where count == LATENCY-1, go to DONE and register mem_rdata into the owner's rdata output; the other side's rdata output holds.
  - BUSY lasts exactly LATENCY cycles.
  - mem_we = 1 only in the final BUSY cycle of a write (a single write strobe); mem_we = 0 otherwise.
  - On a write, the rdata outputs are not updated.
- DONE: owner's done = 1 for exactly this cycle; mem_en = 0. Requests are ignored in DONE. Next edge → IDLE.
- Latency: request sampled at edge 0 → done high in the cycle between edges LATENCY and LATENCY+1. The earliest next grant is at edge LATENCY+2.
- Requester rule: deassert req at the edge that samples done. A req still high at edge LATENCY+2 is treated as a new request.
- Requester address/data/we changes after the grant edge are ignored; the latched values are used.
- A request arriving while BUSY/DONE waits; req must be held until served.
- The rdata outputs hold their last value until the next read completes for that side.
- The count has enough width for LATENCY; it never wraps in operation, and it clears to 0 on every grant.
- Reset mid-access (BUSY or DONE): abort immediately. No done pulse, mem_we forced 0, state IDLE, pointer reinitialised. A write aborted before its final BUSY cycle is never issued.
- Same-edge reset and request: reset wins; no grant.
- Never grant both sides; i_done and d_done are never high together.

Test Plan:
- I-only read, i_addr=0x0000_0010, memory block 2 = 0x1111_2222_3333_4444 → mem_addr=2 for 20 cycles; i_done high exactly at cycle 21 after grant; i_rdata=0x1111_2222_3333_4444; d_done stays 0.
- d_req and i_req both raised in the same cycle right after reset → D served first (done at +21), I granted at edge 22, i_done at +43; the pointer alternates on further ties.
- D write, d_addr=0x40, d_wdata=0xDEAD_BEEF_0000_0001 → mem_we high for exactly one cycle (the 20th BUSY cycle) with mem_addr=8; d_done pulses; d_rdata unchanged; a following D read of 0x40 returns 0xDEAD_BEEF_0000_0001.
- i_addr changed from 0x10 to 0x80 mid-access → mem_addr stays 2 for the whole access; the data returned is block 2.
- Reset asserted at BUSY cycle 10 of a write → no done, mem_we never high, busy=0 next cycle; a fresh request afterward completes normally.
- LATENCY=2 instance: request at edge 0 → mem_en for 2 cycles, done in the cycle after edge 2; a held request is regranted at edge 4.
